// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one bit per clock.
// Define BCD2BIN_DIGIT_CHECK_EN to reject inputs holding a digit above 9 (err flag).
module bcd2bin_seq #(
    parameter int W = 10,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [4*D-1:0] bcd_in,
    output logic [W-1:0]   bin_out,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [4*D-1:0]   dig, dig_nxt;
    logic [W-1:0]     sr, sr_nxt;
    logic [CW-1:0]    cnt;
    logic [4*D+W-1:0] cat;
    logic             accept, last, bad;

    // Each digit that received a bit from the digit above gained 8 where 5 was meant.
    function automatic logic [4*D-1:0] dabble_fix(input logic [4*D-1:0] d);
        logic [4*D-1:0] r;
        r = d;
        for (int i = 0; i < D; i++)
            if (d[4*i+3]) r[4*i +: 4] = d[4*i +: 4] - 4'd3;
        return r;
    endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
    function automatic logic any_bad(input logic [4*D-1:0] d);
        logic b;
        b = 1'b0;
        for (int i = 0; i < D; i++)
            if (d[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    assign bad = any_bad(bcd_in);
`else
    assign bad = 1'b0;
`endif

    assign accept  = start && (state != SHIFT);
    assign last    = (cnt == CW'(W - 1));
    assign cat     = {dig, sr} >> 1;
    assign dig_nxt = dabble_fix(cat[4*D+W-1:W]);
    assign sr_nxt  = cat[W-1:0];
    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)            state_nxt = bad ? DONE : SHIFT;
                else if (state == DONE) state_nxt = IDLE;
            end
            SHIFT:   if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dig     <= '0;
            sr      <= '0;
            cnt     <= '0;
            bin_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dig <= bcd_in;
                sr  <= '0;
                cnt <= '0;
                if (bad) bin_out <= '0;
            end else if (state == SHIFT) begin
                dig <= dig_nxt;
                sr  <= sr_nxt;
                cnt <= cnt + 1'b1;
                if (last) bin_out <= sr_nxt;
            end
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)         err <= 1'b0;
        else if (accept) err <= bad;
    end
`else
    assign err = 1'b0;
`endif

endmodule
